// File: rtl/spi_sram_ctrl_if.sv
// CPU-side byte bus for the SPI SRAM controller.
// master = CPU, slave = controller.
interface spi_sram_ctrl_if;
  logic        mem_req;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        busy;

  modport master (
    output mem_req, mem_read, mem_write,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, busy
  );

  modport slave (
    input  mem_req, mem_read, mem_write,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_ready, busy
  );
endinterface

// File: rtl/spi_sram_ctrl.sv
// Byte bus to SPI mode-0 serial SRAM bridge (byte mode).
// Define SPI_SRAM_RDCACHE_EN for a one-entry read cache.
module spi_sram_ctrl #(
  parameter int unsigned CLK_DIV = 1,
  parameter logic [7:0]  CMD_RD  = 8'h03,
  parameter logic [7:0]  CMD_WR  = 8'h02
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_sram_ctrl_if.slave bus,
  output logic           spi_cs_n,
  output logic           spi_sclk,
  output logic           spi_mosi,
  input  logic           spi_miso
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_END,
    S_DONE
  } state_t;

  state_t      state;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        op_wr;
  logic        op_rd;
  logic [31:0] frame;
  logic [7:0]  rx;
  logic [15:0] div_cnt;
  logic [4:0]  bit_cnt;
  logic [7:0]  cmd;

`ifdef SPI_SRAM_RDCACHE_EN
  logic        c_valid;
  logic [15:0] c_tag;
  logic [7:0]  c_data;
  logic        c_hit;

  // Read hit against the single cached entry.
  assign c_hit = !bus.mem_write && bus.mem_read
              && c_valid && (c_tag == bus.mem_addr);
`endif

  assign cmd = op_wr ? CMD_WR : CMD_RD;

  // Transaction FSM; all bus and SPI outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      op_wr         <= 1'b0;
      op_rd         <= 1'b0;
      frame         <= '0;
      rx            <= '0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      spi_cs_n      <= 1'b1;
      spi_sclk      <= 1'b0;
      spi_mosi      <= 1'b0;
      bus.mem_rdata <= 8'h00;
      bus.mem_ready <= 1'b0;
      bus.busy      <= 1'b0;
`ifdef SPI_SRAM_RDCACHE_EN
      c_valid       <= 1'b0;
      c_tag         <= '0;
      c_data        <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          bus.mem_ready <= 1'b0;
          if (bus.mem_req) begin
            addr_q   <= bus.mem_addr;
            wdata_q  <= bus.mem_wdata;
            op_wr    <= bus.mem_write;
            op_rd    <= !bus.mem_write && bus.mem_read;
            bus.busy <= 1'b1;
            if (!bus.mem_write && !bus.mem_read) begin
              bus.mem_ready <= 1'b1;
              state         <= S_DONE;
            end
`ifdef SPI_SRAM_RDCACHE_EN
            else if (c_hit) begin
              bus.mem_rdata <= c_data;
              bus.mem_ready <= 1'b1;
              state         <= S_DONE;
            end
`endif
            else begin
              state <= S_START;
            end
          end
        end
        S_START: begin
          spi_cs_n <= 1'b0;
          spi_sclk <= 1'b0;
          frame    <= {cmd, addr_q,
                       op_wr ? wdata_q : 8'h00};
          spi_mosi <= cmd[7];
          div_cnt  <= '0;
          bit_cnt  <= '0;
          state    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
              rx       <= {rx[6:0], spi_miso};
            end else begin
              spi_sclk <= 1'b0;
              if (bit_cnt == 5'd31) begin
                state <= S_END;
              end else begin
                bit_cnt  <= bit_cnt + 5'd1;
                frame    <= {frame[30:0], 1'b0};
                spi_mosi <= frame[30];
              end
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        S_END: begin
          spi_cs_n      <= 1'b1;
          spi_sclk      <= 1'b0;
          spi_mosi      <= 1'b0;
          bus.mem_ready <= 1'b1;
          if (op_rd) begin
            bus.mem_rdata <= rx;
          end
`ifdef SPI_SRAM_RDCACHE_EN
          if (op_rd) begin
            c_valid <= 1'b1;
            c_tag   <= addr_q;
            c_data  <= rx;
          end else if (op_wr && c_valid
                       && c_tag == addr_q) begin
            c_data <= wdata_q;
          end
`endif
          state <= S_DONE;
        end
        S_DONE: begin
          bus.mem_ready <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Directed bench for spi_sram_ctrl: CLK_DIV=1 and
// CLK_DIV=3 instances, each with a small SRAM model.
module tb_spi_sram_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_sram_ctrl_if b0 ();
  spi_sram_ctrl_if b1 ();

  logic cs_n0, sclk0, mosi0, miso0;
  logic cs_n1, sclk1, mosi1, miso1;

  spi_sram_ctrl #(.CLK_DIV(1)) u0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (b0.slave),
    .spi_cs_n (cs_n0),
    .spi_sclk (sclk0),
    .spi_mosi (mosi0),
    .spi_miso (miso0)
  );

  spi_sram_ctrl #(.CLK_DIV(3)) u1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (b1.slave),
    .spi_cs_n (cs_n1),
    .spi_sclk (sclk1),
    .spi_mosi (mosi1),
    .spi_miso (miso1)
  );

  int total = 0;
  int bad = 0;

  // ---- SRAM model, instance 0 ----
  logic [7:0]  mem0 [logic [15:0]];
  logic [31:0] sh0 = '0;
  logic [31:0] frm0 = '0;
  logic [7:0]  rdb0 = '0;
  int rise0 = 0;
  int falls0 = 0;
  int rlast0 = 0;
  initial miso0 = 1'b0;

  always @(negedge cs_n0) begin
    falls0++;
    rise0 = 0;
  end
  always @(posedge cs_n0) rlast0 = rise0;
  always @(posedge sclk0) if (!cs_n0) begin
    sh0 = {sh0[30:0], mosi0};
    rise0++;
    if (rise0 == 24)
      rdb0 = mem0.exists(sh0[15:0]) ? mem0[sh0[15:0]] : 8'h00;
    if (rise0 == 32) begin
      frm0 = sh0;
      if (sh0[31:24] == 8'h02) mem0[sh0[23:8]] = sh0[7:0];
    end
  end
  always @(negedge sclk0) if (!cs_n0) begin
    if (rise0 >= 24 && rise0 < 32) begin
      miso0 = rdb0[7];
      rdb0 = {rdb0[6:0], 1'b0};
    end
  end

  // ---- SRAM model, instance 1 ----
  logic [7:0]  mem1 [logic [15:0]];
  logic [31:0] sh1 = '0;
  logic [31:0] frm1 = '0;
  logic [7:0]  rdb1 = '0;
  int rise1 = 0;
  int rlast1 = 0;
  initial miso1 = 1'b0;

  always @(negedge cs_n1) rise1 = 0;
  always @(posedge cs_n1) rlast1 = rise1;
  always @(posedge sclk1) if (!cs_n1) begin
    sh1 = {sh1[30:0], mosi1};
    rise1++;
    if (rise1 == 24)
      rdb1 = mem1.exists(sh1[15:0]) ? mem1[sh1[15:0]] : 8'h00;
    if (rise1 == 32) frm1 = sh1;
  end
  always @(negedge sclk1) if (!cs_n1) begin
    if (rise1 >= 24 && rise1 < 32) begin
      miso1 = rdb1[7];
      rdb1 = {rdb1[6:0], 1'b0};
    end
  end

  // SCLK phase lengths (in clk cycles) on instance 1
  int ph_min = 999;
  int ph_max = 0;
  int run = 0;
  logic pv = 1'b0;
  logic prev = 1'b0;
  always @(negedge clk) begin
    if (cs_n1 !== 1'b0) pv = 1'b0;
    else if (!pv) begin
      pv = 1'b1; prev = sclk1; run = 1;
    end else if (sclk1 == prev) run++;
    else begin
      if (run < ph_min) ph_min = run;
      if (run > ph_max) ph_max = run;
      prev = sclk1; run = 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input int k, input logic rq,
                         input logic wr, input logic rd,
                         input logic [15:0] a,
                         input logic [7:0] d);
    if (k == 0) begin
      b0.mem_req = rq; b0.mem_write = wr;
      b0.mem_read = rd; b0.mem_addr = a;
      b0.mem_wdata = d;
    end else begin
      b1.mem_req = rq; b1.mem_write = wr;
      b1.mem_read = rd; b1.mem_addr = a;
      b1.mem_wdata = d;
    end
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? b0.mem_ready : b1.mem_ready;
  endfunction

  // Issue one request; lat = edges after accept
  // until mem_ready is seen (-1 on timeout).
  task automatic access(input int k, input logic wr,
                        input logic rd,
                        input logic [15:0] a,
                        input logic [7:0] d,
                        input logic keep,
                        output int lat);
    @(negedge clk);
    set_bus(k, 1'b1, wr, rd, a, d);
    @(posedge clk); #1;
    lat = 0;
    while (!rdy(k) && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rdy(k)) begin
      lat = -1;
      chk("timeout", 32'd1, 32'd0);
    end
    if (!keep) begin
      set_bus(k, 1'b0, 1'b0, 1'b0, a, d);
      @(posedge clk); #1;
    end
  endtask

  int lat;
  int f;
  logic seen;

  initial begin
    set_bus(0, 0, 0, 0, 16'h0, 8'h0);
    set_bus(1, 0, 0, 0, 16'h0, 8'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", cs_n0, 1);
    chk("rst_sclk", sclk0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_ready", b0.mem_ready, 0);
    chk("rst_busy", b0.busy, 0);
    chk("rst_rdata", b0.mem_rdata, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // reset in the middle of SHIFT
    @(negedge clk);
    set_bus(0, 1, 1, 0, 16'h0100, 8'h55);
    repeat (20) @(posedge clk);
    #1;
    chk("mid_busy", b0.busy, 1);
    chk("mid_cs_n", cs_n0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    set_bus(0, 0, 0, 0, 16'h0, 8'h0);
    @(posedge clk); #1;
    chk("mrst_cs_n", cs_n0, 1);
    chk("mrst_sclk", sclk0, 0);
    chk("mrst_ready", b0.mem_ready, 0);
    chk("mrst_busy", b0.busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (b0.mem_ready) seen = 1'b1;
    end
    chk("mrst_no_ready", seen, 0);
    chk("mrst_no_write", mem0.exists(16'h0100), 0);

    // write A5 to 1234
    access(0, 1, 0, 16'h1234, 8'hA5, 0, lat);
    chk("wr_lat", lat, 66);
    chk("wr_frame", frm0, 32'h021234A5);
    chk("wr_rises", rlast0, 32);
    chk("wr_mem", mem0[16'h1234], 8'hA5);

    // read 1234, model returns 5A
    mem0[16'h1234] = 8'h5A;
    access(0, 0, 1, 16'h1234, 8'h00, 0, lat);
    chk("rd_lat", lat, 66);
    chk("rd_hdr", frm0[31:8], 24'h031234);
    chk("rd_rises", rlast0, 32);
    chk("rd_data", b0.mem_rdata, 8'h5A);

    // CLK_DIV=3 read of FFFF
    mem1[16'hFFFF] = 8'hC3;
    access(1, 0, 1, 16'hFFFF, 8'h00, 0, lat);
    chk("d3_lat", lat, 194);
    chk("d3_data", b1.mem_rdata, 8'hC3);
    chk("d3_hdr", frm1[31:8], 24'h03FFFF);
    chk("d3_rises", rlast1, 32);
    chk("d3_ph_min", ph_min, 3);
    chk("d3_ph_max", ph_max, 3);

    // back-to-back write then read, req held
    f = falls0;
    access(0, 1, 0, 16'h0010, 8'h77, 1, lat);
    access(0, 0, 1, 16'h0010, 8'h00, 0, lat);
    chk("b2b_frames", falls0 - f, 2);
    chk("b2b_mem", mem0[16'h0010], 8'h77);
    chk("b2b_data", b0.mem_rdata, 8'h77);

    // write has priority over read
    access(0, 1, 1, 16'h0040, 8'h9E, 0, lat);
    chk("prio_cmd", frm0[31:24], 8'h02);
    chk("prio_mem", mem0[16'h0040], 8'h9E);
    chk("prio_rdata", b0.mem_rdata, 8'h77);

    // neither read nor write: no SPI traffic
    f = falls0;
    access(0, 0, 0, 16'h0050, 8'h00, 0, lat);
    chk("nop_lat", lat, 0);
    chk("nop_frames", falls0 - f, 0);
    chk("nop_rdata", b0.mem_rdata, 8'h77);

    // read cache sequence on 0020
    mem0[16'h0020] = 8'h3C;
    f = falls0;
    access(0, 0, 1, 16'h0020, 8'h00, 0, lat);
    chk("c1_lat", lat, 66);
    chk("c1_data", b0.mem_rdata, 8'h3C);
    chk("c1_frames", falls0 - f, 1);
    f = falls0;
    access(0, 0, 1, 16'h0020, 8'h00, 0, lat);
    chk("c2_data", b0.mem_rdata, 8'h3C);
`ifdef SPI_SRAM_RDCACHE_EN
    chk("c2_lat", lat, 0);
    chk("c2_frames", falls0 - f, 0);
`else
    chk("c2_lat", lat, 66);
    chk("c2_frames", falls0 - f, 1);
`endif
    f = falls0;
    access(0, 1, 0, 16'h0020, 8'h11, 0, lat);
    chk("c3_lat", lat, 66);
    chk("c3_frames", falls0 - f, 1);
    chk("c3_mem", mem0[16'h0020], 8'h11);
    f = falls0;
    access(0, 0, 1, 16'h0020, 8'h00, 0, lat);
    chk("c4_data", b0.mem_rdata, 8'h11);
`ifdef SPI_SRAM_RDCACHE_EN
    chk("c4_lat", lat, 0);
    chk("c4_frames", falls0 - f, 0);
`else
    chk("c4_lat", lat, 66);
    chk("c4_frames", falls0 - f, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
